// File: rtl/idelay_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : idelay_pkg                                                    |
// | Purpose    : Shared types and default constants for the IDELAY eye scan:   |
// |              the scan-state enum, the 9-bit tap type, the run-length and   |
// |              error-count types, and the counter-width helper.              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package idelay_pkg;

  localparam int c_tap_w = 9;
  localparam int c_len_w = 10;
  localparam int c_err_w = 16;

  localparam int c_def_tap_max    = 511;
  localparam int c_def_step       = 8;
  localparam int c_def_dwell_log2 = 10;
  localparam int c_def_settle     = 16;
  localparam int c_def_err_thresh = 0;
  localparam int c_def_timeout    = 1024;

  typedef logic [c_tap_w-1:0] tap_t;
  typedef logic [c_len_w-1:0] len_t;
  typedef logic [c_err_w-1:0] err_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SET      = 4'd1,
    ST_WAIT_RDY = 4'd2,
    ST_SETTLE   = 4'd3,
    ST_DWELL    = 4'd4,
    ST_EVAL     = 4'd5,
    ST_CENTER   = 4'd6,
    ST_WAIT_FIN = 4'd7,
    ST_FAIL     = 4'd8,
    ST_DONE     = 4'd9
  } scan_state_t;

  // Width of a single shared cycle counter able to reach the largest of the
  // three terminal counts (timeout, settle, dwell).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_err_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : pattern_err_counter                                           |
// | Purpose    : Compares each deserialized word against the training pattern |
// |              and counts mismatches in a 16-bit saturating counter.         |
// | Ports      : clk160, rstb (async, active-low)                              |
// |              clr      - zero the counter (wins over en)                    |
// |              en       - count mismatches this cycle                        |
// |              pattern  - expected training word                             |
// |              data_in  - received lane word                                 |
// |              pass     - error count <= ERR_THRESH                          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module pattern_err_counter
  import idelay_pkg::*;
#(
  parameter int ERR_THRESH = c_def_err_thresh
) (
  input  logic       clk160,
  input  logic       rstb,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] pattern,
  input  logic [7:0] data_in,
  output logic       pass
);

  localparam err_t c_thresh = err_t'(ERR_THRESH);

  err_t r_err;

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      r_err <= '0;
    end else if (clr) begin
      r_err <= '0;
    end else if (en && (data_in != pattern) && (r_err != '1)) begin
      r_err <= r_err + err_t'(1);
    end
  end

  assign pass = (r_err <= c_thresh);

endmodule
`default_nettype wire

// File: rtl/idelay_eye_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : idelay_eye_scan                                               |
// | Purpose    : Sweeps one IDELAY lane across its tap range, measures the     |
// |              training-pattern error count at each point, tracks the        |
// |              longest contiguous passing run and parks the delay at its     |
// |              centre.                                                       |
// | Ports      : clk160, rstb (async, active-low)                              |
// |              start        - scan request, honoured only when idle          |
// |              pattern      - expected training word                         |
// |              data_in      - deserialized lane word                         |
// |              delay_ready  - downstream IDELAY has reached delay_target     |
// |              delay_target - tap request to the IDELAY set controller       |
// |              busy / done  - scan in progress / scan complete (level)       |
// |              scan_fail    - no passing point or downstream timeout         |
// |              eye_start    - first tap of the chosen run                    |
// |              eye_width    - passing points x STEP                          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module idelay_eye_scan
  import idelay_pkg::*;
#(
  parameter int TAP_MAX    = c_def_tap_max,
  parameter int STEP       = c_def_step,
  parameter int DWELL_LOG2 = c_def_dwell_log2,
  parameter int SETTLE     = c_def_settle,
  parameter int ERR_THRESH = c_def_err_thresh,
  parameter int TIMEOUT    = c_def_timeout
) (
  input  logic       clk160,
  input  logic       rstb,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [7:0] data_in,
  input  logic       delay_ready,
  output tap_t       delay_target,
  output logic       busy,
  output logic       done,
  output logic       scan_fail,
  output tap_t       eye_start,
  output logic [9:0] eye_width
);

  localparam int                 c_cnt_w       = cnt_width(TIMEOUT, SETTLE, 1 << DWELL_LOG2);
  localparam logic [c_cnt_w-1:0] c_tmo_last    = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE - 1);
  localparam logic [c_cnt_w-1:0] c_dwell_last  = c_cnt_w'((1 << DWELL_LOG2) - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
  localparam logic [9:0]         c_tap_max     = 10'(TAP_MAX);
  localparam logic [9:0]         c_step        = 10'(STEP);

  scan_state_t        r_state;
  scan_state_t        w_next;
  logic [c_cnt_w-1:0] r_cnt;
  tap_t               r_tap;
  tap_t               r_cur_start;
  tap_t               r_best_start;
  len_t               r_cur_len;
  len_t               r_best_len;

  logic [9:0] w_tap_sum;
  logic       w_tap_over;
  logic       w_pass;
  logic       w_err_clr;
  logic       w_err_en;
  len_t       w_new_len;
  tap_t       w_new_start;

  assign w_err_clr = (r_state == ST_SETTLE);
  assign w_err_en  = (r_state == ST_DWELL);

  pattern_err_counter #(
    .ERR_THRESH (ERR_THRESH)
  ) u_err_cnt (
    .clk160  (clk160),
    .rstb    (rstb),
    .clr     (w_err_clr),
    .en      (w_err_en),
    .pattern (pattern),
    .data_in (data_in),
    .pass    (w_pass)
  );

  // Next tap is formed one bit wider than a tap so the end-of-range test
  // cannot be fooled by a wrap past TAP_MAX.
  always_comb begin
    w_tap_sum   = {1'b0, r_tap} + c_step;
    w_tap_over  = (w_tap_sum > c_tap_max);
    w_new_len   = r_cur_len + len_t'(1);
    w_new_start = (r_cur_len == '0) ? r_tap : r_cur_start;

    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_SET;
      ST_SET:      w_next = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (delay_ready)              w_next = ST_SETTLE;
        else if (r_cnt == c_tmo_last) w_next = ST_FAIL;
      end
      ST_SETTLE:   if (r_cnt == c_settle_last) w_next = ST_DWELL;
      ST_DWELL:    if (r_cnt == c_dwell_last)  w_next = ST_EVAL;
      ST_EVAL:     w_next = w_tap_over ? ST_CENTER : ST_SET;
      ST_CENTER:   w_next = (r_best_len == '0) ? ST_FAIL : ST_WAIT_FIN;
      ST_WAIT_FIN: begin
        if (delay_ready)              w_next = ST_DONE;
        else if (r_cnt == c_tmo_last) w_next = ST_FAIL;
      end
      ST_FAIL:     w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // One cycle counter serves timeout, settle and dwell: it restarts from zero
  // on every state change, so each state sees its own elapsed cycles.
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : (r_cnt + c_cnt_one);
    end
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      r_tap        <= '0;
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
      delay_target <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      scan_fail    <= 1'b0;
      eye_start    <= '0;
      eye_width    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            done         <= 1'b0;
            scan_fail    <= 1'b0;
            r_tap        <= '0;
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
          end
        end
        ST_SET: delay_target <= r_tap;
        ST_EVAL: begin
          if (w_pass) begin
            r_cur_len   <= w_new_len;
            r_cur_start <= w_new_start;
            // Strictly greater: on a tie the earlier run is kept.
            if (w_new_len > r_best_len) begin
              r_best_len   <= w_new_len;
              r_best_start <= w_new_start;
            end
          end else begin
            r_cur_len <= '0;
          end
          if (!w_tap_over) r_tap <= w_tap_sum[c_tap_w-1:0];
        end
        ST_CENTER: begin
          if (r_best_len != '0) begin
            delay_target <= r_best_start
                          + tap_t'(((32'(r_best_len) - 32'd1) * STEP) / 2);
            eye_start    <= r_best_start;
            eye_width    <= 10'(32'(r_best_len) * STEP);
          end
        end
        ST_FAIL: begin
          delay_target <= '0;
          scan_fail    <= 1'b1;
          eye_width    <= '0;
        end
        ST_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idelay_eye_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_idelay_eye_scan                                            |
// | Purpose    : Directed self-checking bench for idelay_eye_scan. A simple   |
// |              IDELAY model slews delay_out toward delay_target (<=8 taps    |
// |              every 9 cycles) and returns the training word only inside the |
// |              configured eye window(s). Dwell and settle are shortened so a |
// |              full 64-point sweep stays short; the tap grid is unchanged.   |
// |              A second instance (ERR_THRESH=2, single scan point) exercises |
// |              the error threshold with a controlled mismatch count.         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_idelay_eye_scan;
  import idelay_pkg::*;

  logic clk160 = 1'b0;
  always #5 clk160 = ~clk160;

  logic       rstb;
  logic       start;
  logic       hold_low;
  logic [7:0] pattern;
  logic [7:0] data_in;
  logic       delay_ready;
  tap_t       delay_target;
  tap_t       eye_start;
  logic       busy;
  logic       done;
  logic       scan_fail;
  logic [9:0] eye_width;

  assign pattern = 8'hA5;

  int eye_lo  = -1;
  int eye_hi  = -1;
  int eye_lo2 = -1;
  int eye_hi2 = -1;

  // IDELAY model
  tap_t delay_out = '0;
  int   div       = 0;
  always @(posedge clk160) begin
    if (div == 8) begin
      div <= 0;
      if (delay_out < delay_target)
        delay_out <= ((delay_target - delay_out) > 9'd8) ? delay_out + 9'd8 : delay_target;
      else if (delay_out > delay_target)
        delay_out <= ((delay_out - delay_target) > 9'd8) ? delay_out - 9'd8 : delay_target;
    end else begin
      div <= div + 1;
    end
  end

  assign delay_ready = !hold_low && (delay_out == delay_target);
  assign data_in = ((int'(delay_out) >= eye_lo  && int'(delay_out) <= eye_hi) ||
                    (int'(delay_out) >= eye_lo2 && int'(delay_out) <= eye_hi2))
                   ? pattern : ~pattern;

  idelay_eye_scan #(
    .TAP_MAX(511), .STEP(8), .DWELL_LOG2(4), .SETTLE(2), .ERR_THRESH(0), .TIMEOUT(1024)
  ) dut (
    .clk160       (clk160),
    .rstb         (rstb),
    .start        (start),
    .pattern      (pattern),
    .data_in      (data_in),
    .delay_ready  (delay_ready),
    .delay_target (delay_target),
    .busy         (busy),
    .done         (done),
    .scan_fail    (scan_fail),
    .eye_start    (eye_start),
    .eye_width    (eye_width)
  );

  // Threshold instance: one scan point (tap 0), always ready. The mismatch
  // pattern has period 16 = dwell length, so every dwell sees exactly nerr.
  logic       start2;
  logic       rdy2;
  logic [7:0] data_in2;
  tap_t       delay_target2;
  tap_t       eye_start2;
  logic       busy2;
  logic       done2;
  logic       scan_fail2;
  logic [9:0] eye_width2;
  int         nerr = 0;
  int         cyc  = 0;

  always @(posedge clk160) cyc <= cyc + 1;
  assign rdy2     = 1'b1;
  assign data_in2 = ((cyc % 16) < nerr) ? (pattern ^ 8'h01) : pattern;

  idelay_eye_scan #(
    .TAP_MAX(7), .STEP(8), .DWELL_LOG2(4), .SETTLE(2), .ERR_THRESH(2), .TIMEOUT(1024)
  ) dut_t2 (
    .clk160       (clk160),
    .rstb         (rstb),
    .start        (start2),
    .pattern      (pattern),
    .data_in      (data_in2),
    .delay_ready  (rdy2),
    .delay_target (delay_target2),
    .busy         (busy2),
    .done         (done2),
    .scan_fail    (scan_fail2),
    .eye_start    (eye_start2),
    .eye_width    (eye_width2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  int scan_cyc;
  int scan_max;
  int early_busy;
  int early_tgt;

  // Pulse start and wait (bounded) for done; records scan length, the highest
  // target requested and busy/target two cycles after acceptance.
  task automatic run_scan(input int budget);
    scan_cyc   = 0;
    scan_max   = 0;
    early_busy = 0;
    early_tgt  = -1;
    @(negedge clk160); start = 1'b1;
    @(negedge clk160); start = 1'b0;
    while (!done && scan_cyc < budget) begin
      @(negedge clk160);
      scan_cyc++;
      if (int'(delay_target) > scan_max) scan_max = int'(delay_target);
      if (scan_cyc == 2) begin
        early_busy = int'(busy);
        early_tgt  = int'(delay_target);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk160);
      n++;
    end
  endtask

  // Wait until the DUT has settled on the given scan point, then move a few
  // cycles further so the block is inside that point's dwell window.
  task automatic wait_dwell(input int tap);
    int n = 0;
    while (!((int'(delay_target) == tap) && delay_ready) && n < 3000) begin
      @(negedge clk160);
      n++;
    end
    chk("reach_point", int'(delay_target), tap);
    repeat (5) @(negedge clk160);
  endtask

  task automatic chk_scan(input string p, input int fail, input int st,
                          input int wd, input int tgt);
    chk({p, "_done"}, int'(done), 1);
    chk({p, "_scan_fail"}, int'(scan_fail), fail);
    if (st >= 0) chk({p, "_eye_start"}, int'(eye_start), st);
    chk({p, "_eye_width"}, int'(eye_width), wd);
    chk({p, "_delay_target"}, int'(delay_target), tgt);
  endtask

  task automatic run_t2(input string p, input int errs, input int fail, input int wd);
    int n = 0;
    nerr = errs;
    @(negedge clk160); start2 = 1'b1;
    @(negedge clk160); start2 = 1'b0;
    while (!done2 && n < 500) begin
      @(negedge clk160);
      n++;
    end
    chk({p, "_done"}, int'(done2), 1);
    chk({p, "_scan_fail"}, int'(scan_fail2), fail);
    chk({p, "_eye_width"}, int'(eye_width2), wd);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb     = 1'b0;
    start    = 1'b0;
    start2   = 1'b0;
    hold_low = 1'b0;
    repeat (3) @(negedge clk160);

    chk("rst_delay_target", int'(delay_target), 0);
    chk("rst_busy",         int'(busy),         0);
    chk("rst_done",         int'(done),         0);
    chk("rst_scan_fail",    int'(scan_fail),    0);
    chk("rst_eye_start",    int'(eye_start),    0);
    chk("rst_eye_width",    int'(eye_width),    0);
    rstb = 1'b1;
    @(negedge clk160);

    // 1: eye 120..200 -> 11 points
    eye_lo = 120; eye_hi = 200;
    run_scan(6000);
    chk("s1_busy_early", early_busy, 1);
    chk("s1_tgt_early",  early_tgt,  0);
    chk_scan("s1", 0, 120, 88, 160);
    chk("s1_busy_end", int'(busy), 0);

    // 2a: two eyes; scan points are multiples of 8, so 300..360 passes 304..360
    eye_lo = 40; eye_hi = 64; eye_lo2 = 300; eye_hi2 = 360;
    run_scan(6000);
    chk_scan("s2a", 0, 304, 64, 332);

    // 2b: equal-length eyes, earlier one wins
    eye_lo = 40; eye_hi = 64; eye_lo2 = 200; eye_hi2 = 224;
    run_scan(6000);
    chk_scan("s2b", 0, 40, 32, 52);

    // 3: no passing point
    eye_lo = -1; eye_hi = -1; eye_lo2 = -1; eye_hi2 = -1;
    run_scan(6000);
    chk_scan("s3", 1, -1, 0, 0);

    // 4: eye at the top of the range
    eye_lo = 480; eye_hi = 511;
    run_scan(6000);
    chk_scan("s4", 0, 480, 32, 492);
    chk("s4_max_scan_tap", scan_max, 504);

    // 5: downstream never ready -> SET + 1024 WAIT_RDY + FAIL + DONE
    hold_low = 1'b1;
    run_scan(3000);
    chk("s5_cycles", scan_cyc, 1027);
    chk_scan("s5", 1, -1, 0, 0);
    hold_low = 1'b0;

    // 5b: error threshold of 2
    run_t2("t2_three_err", 3, 1, 0);
    run_t2("t2_two_err",   2, 0, 8);

    // 6a: start pulse mid-dwell is ignored
    eye_lo = 120; eye_hi = 200;
    @(negedge clk160); start = 1'b1;
    @(negedge clk160); start = 1'b0;
    wait_dwell(128);
    start = 1'b1;
    @(negedge clk160); start = 1'b0;
    @(negedge clk160);
    chk("s6_busy_kept", int'(busy), 1);
    chk("s6_tgt_kept",  int'(delay_target), 128);
    wait_done(6000);
    chk_scan("s6a", 0, 120, 88, 160);

    // 6b: asynchronous reset mid-dwell
    @(negedge clk160); start = 1'b1;
    @(negedge clk160); start = 1'b0;
    wait_dwell(128);
    #2 rstb = 1'b0;
    #1;
    chk("s6_rst_delay_target", int'(delay_target), 0);
    chk("s6_rst_busy",         int'(busy),         0);
    chk("s6_rst_done",         int'(done),         0);
    chk("s6_rst_scan_fail",    int'(scan_fail),    0);
    chk("s6_rst_eye_start",    int'(eye_start),    0);
    chk("s6_rst_eye_width",    int'(eye_width),    0);
    @(negedge clk160);
    rstb = 1'b1;

    // 6c: clean scan after reset matches scenario 1
    run_scan(6000);
    chk_scan("s6c", 0, 120, 88, 160);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
